// File: rtl/control_sequencer.sv
// Hard-wired SRC control unit: steps each instruction through fetch (T0-T2) and
// execute (T3-T7) micro-steps, with memory ready-handshake stalls.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_data,
  input  logic        CON_out,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [4:0]  alu_op,
  output logic        Run
);

  localparam logic [3:0] RST  = 4'd0;
  localparam logic [3:0] T0   = 4'd1;
  localparam logic [3:0] T1   = 4'd2;
  localparam logic [3:0] T2   = 4'd3;
  localparam logic [3:0] T3   = 4'd4;
  localparam logic [3:0] T4   = 4'd5;
  localparam logic [3:0] T5   = 4'd6;
  localparam logic [3:0] T6   = 4'd7;
  localparam logic [3:0] T7   = 4'd8;
  localparam logic [3:0] HALT = 4'd9;

  localparam logic [3:0] C_LD   = 4'd0;
  localparam logic [3:0] C_LDI  = 4'd1;
  localparam logic [3:0] C_ST   = 4'd2;
  localparam logic [3:0] C_ALU  = 4'd3;
  localparam logic [3:0] C_IMM  = 4'd4;
  localparam logic [3:0] C_BR   = 4'd5;
  localparam logic [3:0] C_JR   = 4'd6;
  localparam logic [3:0] C_NOP  = 4'd7;
  localparam logic [3:0] C_HALT = 4'd8;

  logic [3:0] state_r;
  logic [3:0] next_s;
  logic [4:0] opcode_r;
  logic [3:0] cls_s;

  function automatic logic [3:0] op_class(input logic [4:0] op);
    case (op)
      5'b00000: op_class = C_LD;
      5'b00001: op_class = C_LDI;
      5'b00010: op_class = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: op_class = C_ALU;
      5'b01011, 5'b01100, 5'b01101: op_class = C_IMM;
      5'b10010: op_class = C_BR;
      5'b10011: op_class = C_JR;
      5'b11010: op_class = C_HALT;
      default:  op_class = C_NOP;
    endcase
  endfunction

  assign cls_s = op_class(opcode_r);

  // State register and opcode latch (opcode captured on the T2->T3 edge)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= RST;
      opcode_r <= 5'd0;
    end else begin
      state_r <= next_s;
      if (state_r == T2) opcode_r <= IR_data[31:27];
    end
  end

  // Next-state sequencing, including memory wait holds
  always_comb begin
    next_s = state_r;
    case (state_r)
      RST: next_s = T0;
      T0:  next_s = T1;
      T1:  next_s = mem_ready ? T2 : T1;
      T2:  next_s = T3;
      T3: begin
        case (cls_s)
          C_JR, C_NOP: next_s = T0;
          C_HALT:      next_s = HALT;
          default:     next_s = T4;
        endcase
      end
      T4: next_s = T5;
      T5: next_s = (cls_s == C_LD || cls_s == C_ST || cls_s == C_BR) ? T6 : T0;
      T6: begin
        case (cls_s)
          C_LD:    next_s = mem_ready ? T7 : T6;
          C_ST:    next_s = T7;
          default: next_s = T0;
        endcase
      end
      T7: next_s = (cls_s == C_ST && !mem_ready) ? T7 : T0;
      HALT: next_s = HALT;
      default: next_s = RST;
    endcase
  end

  // Moore strobe decode from state and latched opcode; PCin in T1/T6 is gated by handshake/condition
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    CONin = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0;
    Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
    alu_op = 5'd0;
    Run = (state_r != RST) && (state_r != HALT);
    case (state_r)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1; PCin = mem_ready; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        case (cls_s)
          C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (cls_s)
          C_ALU:             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode_r; end
          C_IMM:             begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode_r; end
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = 5'b00011; end
          C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (cls_s)
          C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
          C_BR:                begin Cout = 1'b1; Zin = 1'b1; alu_op = 5'b00011; end
          default: ;
        endcase
      end
      T6: begin
        case (cls_s)
          C_LD:    begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_BR:    begin Zlowout = 1'b1; PCin = CON_out; end
          default: ;
        endcase
      end
      T7: begin
        case (cls_s)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hard-wired control unit for the SRC datapath. It sits directly upstream of the register select/encode stage. It steps each instruction through fetch and execute micro-steps. In each step it drives the register-field strobes (Gra/Grb/Grc, Rin/Rout/BAout, Cout) consumed by the select/encode stage, plus the PC, MAR/MDR, IR, Y/Z, CON and memory strobes. Memory transfers use a ready handshake, so variable-latency memory stalls the sequence.

## Interface
- No parameters; opcode encodings are fixed (below).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state RST
- IR_data  in  32  instruction register contents; opcode = IR_data[31:27]
- CON_out  in  1  branch-condition flag from the CON FF
- mem_ready  in  1  memory has completed the current Read/Write this cycle
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, CONin  out  1 each  datapath strobes
- Read, Write  out  1 each  memory requests
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  to select/encode stage
- alu_op  out  5  ALU operation code, valid while Zin=1, else 0
- Run  out  1  high while executing; low in RST and HALT

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, add..rol 00011–01010 (reg-reg ALU), addi 01011, andi 01100, ori 01101, br 10010, jr 10011, nop 11001, halt 11010. Every other opcode executes as nop.
- States: RST, T0–T7, HALT. Outputs are Moore, decoded from the registered state and latched opcode. Every strobe not listed for a step is 0.
- RST: all outputs 0. The first clock edge after reset is released goes to T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin (alu_op=0).
  - T1: Zlowout, PCin, Read, MDRin. Hold in T1 while mem_ready=0. PCin pulses only in the cycle mem_ready=1, so PC is loaded once.
  - T2: MDRout, IRin.
- Opcode latch: the opcode is captured at the end of T2 and drives all execute steps. IR_data changes mid-execute are ignored.
- Reg-reg ALU:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin; then T0.
- Immediate ALU (addi/andi/ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin; then T0.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=00011.
  - T5: Zlowout, Gra, Rin; then T0.
- ld:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; hold until mem_ready=1.
  - T7: MDRout, Gra, Rin; then T0.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write; hold until mem_ready=1; then T0.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, alu_op=00011.
  - T6: Zlowout; PCin only if CON_out=1; then T0.
- jr:
  - T3: Gra, Rout, PCin; then T0.
- nop:
  - T3: no strobes; then T0.
- halt:
  - T3 goes to HALT. In HALT: Run=0, all strobes 0. Only reset leaves HALT.
- Invariants:
  - At most one of Gra/Grb/Grc is high.
  - Rin and Rout/BAout are never high together.
  - Read and Write are never high together.

## Timing
- Reset: async assert forces RST immediately, mid-instruction or mid-memory-wait included. Outputs go to 0 combinationally. A pending Read/Write is abandoned.
- Zero-wait cycle counts (mem_ready tied 1), counted from entry to T0 to the next T0:
  - nop and jr: 4 cycles.
  - ALU, immediate and ldi: 6 cycles.
  - br: 7 cycles.
  - ld and st: 8 cycles.
- Each cycle mem_ready is low in a wait state adds exactly one cycle.
- mem_ready is sampled only in T1 (fetch), ld T6 and st T7. At other times it is ignored.
- A mem_ready high that arrives early in the same cycle as entry still completes that cycle; there is no minimum wait.
- CON_out is sampled only in br T6. CONin in T3 gives the CON FF two cycles to settle.

## Test plan
- Reset then fetch: hold reset high, release; IR opcode=00011 (add), mem_ready=1. Expect RST → T0 → T1 → T2 → T3. Expect Grb+Rout in T3, Grc+Rout+alu_op=00011 in T4, Gra+Rin in T5, then T0; Run=1 throughout.
- Memory wait: mem_ready=0 for 3 cycles in fetch T1. Expect Read and MDRin held 4 cycles and PCin high only in the final cycle. The instruction completes 3 cycles later than zero-wait.
- ld then st (opcodes 00000, 00010) with mem_ready=1. Expect 8 cycles each. ld: BAout in T3 and T7 Gra+Rin. st: T6 Gra+Rout+MDRin, T7 Write, Read=0.
- Branch: br with CON_out=0, then br with CON_out=1. Expect PCin low in T6 for the first and high for the second; 7 cycles each.
- halt (11010) then unknown opcode 11111: expect HALT with Run=0 and all strobes 0 for 20 cycles. After reset, an unknown opcode behaves as nop (4 cycles, no strobes in T3).
- Async reset asserted mid-st T7 while waiting on mem_ready=0. Expect Write to drop the same cycle, state RST, and a clean fetch after release.
